issue_ctrl: RTL and testbench

Issue controller that sits directly upstream of the pairwise hazard checker in the in-order instruction pipeline. It buffers incoming 8-bit instructions and presents each candidate alongside the last issued instruction to the checker. From the returned RAW/WAR/WAW flags it decides whether to insert stall bubbles before releasing the candidate downstream. It also keeps saturating per-class hazard counters for performance monitoring.

---
 rtl/issue_ctrl_pkg.sv | 41 ++++
 rtl/issue_ctrl_if.sv | 30 +++
 rtl/issue_fifo.sv | 56 +++++
 rtl/issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_issue_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: instruction fields, opcodes,
// checker flag positions and the controller state encoding.
// Ports: none (package only).
package issue_ctrl_pkg;

  localparam int INSTR_W = 8;

  // Instruction layout: {op[7:6], r1[5:3], r2[2:0]}
  localparam int OP_HI = 7;
  localparam int OP_LO = 6;
  localparam int R1_HI = 5;
  localparam int R1_LO = 3;
  localparam int R2_HI = 2;
  localparam int R2_LO = 0;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  // Bit positions in the hazard checker's return vector
  localparam int HZ_RAW = 2;
  localparam int HZ_WAR = 1;
  localparam int HZ_WAW = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_STALL = 2'd2,
    ST_OFFER = 2'd3
  } state_t;

  function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic is_nop(input logic [INSTR_W-1:0] instr);
    return instr_op(instr) == OP_NOP;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Handshake bundle between the issue controller, its upstream, the hazard
// checker and the downstream stage.
// Ports: in_* (upstream valid/ready), out_* (downstream valid/ready),
//        pair_x/pair_y (to checker), hz (from checker).
interface issue_ctrl_if;
  import issue_ctrl_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [INSTR_W-1:0] pair_x;
  logic [INSTR_W-1:0] pair_y;
  logic [2:0]         hz;

  // Environment side: upstream producer, downstream consumer and checker
  modport master (
    output in_valid, in_instr, out_ready, hz,
    input  in_ready, out_valid, out_instr, pair_x, pair_y
  );

  // Issue controller side
  modport slave (
    input  in_valid, in_instr, out_ready, hz,
    output in_ready, out_valid, out_instr, pair_x, pair_y
  );

endinterface

// File: rtl/issue_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; head is visible combinationally.
// Latency: a write is visible at the head one cycle later.
// Backpressure: writes are ignored when full unless a read happens in the same cycle.
// Ports: clk, rst_n (sync, active-low), i_flush, i_wr/i_wr_dat, i_rd,
//        o_head, o_empty, o_full, o_count.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_wr,
  input  logic [W-1:0]             i_wr_dat,
  input  logic                     i_rd,
  output logic [W-1:0]             o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_wr;
  logic         w_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count = r_wptr - r_rptr;
  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  assign w_rd = i_rd && !o_empty;
  assign w_wr = i_wr && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= i_wr_dat;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: buffers instructions, consults the pairwise hazard
// checker once per candidate and inserts RAW/WAW stall bubbles before offering it.
// Latency: 2 cycles accept-to-offer when idle, plus RAW_STALL or WAW_STALL on a hazard.
// Backpressure: in_ready drops when the FIFO is full; the offer holds until out_ready.
// Ports: clk, rst_n (sync, active-low), flush, bus (issue_ctrl_if.slave),
//        raw_cnt/war_cnt/waw_cnt (saturating hazard counters).
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int RAW_STALL = 2,
  parameter int WAW_STALL = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  issue_ctrl_if.slave      bus,
  output logic [CNT_W-1:0] raw_cnt,
  output logic [CNT_W-1:0] war_cnt,
  output logic [CNT_W-1:0] waw_cnt
);
  localparam int AW        = $clog2(DEPTH);
  localparam int STALL_MAX = (RAW_STALL > WAW_STALL) ? RAW_STALL : WAW_STALL;
  // The stall counter only ever holds STALL-1 down to 0.
  localparam int SW        = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  state_t             r_state;
  logic [SW-1:0]      r_stall;
  logic [INSTR_W-1:0] r_prev;
  logic               r_prev_valid;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [CNT_W-1:0]   r_raw_cnt;
  logic [CNT_W-1:0]   r_war_cnt;
  logic [CNT_W-1:0]   r_waw_cnt;

  logic [INSTR_W-1:0] w_head;
  logic               w_empty;
  logic               w_full;
  logic [AW:0]        w_count;
  logic               w_push;
  logic               w_pop;
  logic               w_stay;
  logic [2:0]         w_hz_m;

  assign bus.in_ready  = !w_full && !flush && rst_n;
  assign w_push        = bus.in_valid && bus.in_ready;
  // out_valid is high exactly in the offer state, so it stands in for it here.
  assign w_pop         = r_out_valid && bus.out_ready && !flush;
  // A same-cycle write keeps the FIFO occupied even if the popped entry was the last.
  assign w_stay        = (w_count > (AW+1)'(1)) || w_push;

  // Nothing to conflict with after a nop candidate or when no prior issue exists.
  assign w_hz_m        = (r_prev_valid && !is_nop(w_head)) ? bus.hz : 3'b000;

  assign bus.pair_x    = r_prev;
  assign bus.pair_y    = w_empty ? '0 : w_head;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign raw_cnt       = r_raw_cnt;
  assign war_cnt       = r_war_cnt;
  assign waw_cnt       = r_waw_cnt;

  issue_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (flush),
    .i_wr     (w_push),
    .i_wr_dat (bus.in_instr),
    .i_rd     (w_pop),
    .o_head   (w_head),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_count  (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_stall      <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_raw_cnt    <= '0;
      r_war_cnt    <= '0;
      r_waw_cnt    <= '0;
    end else if (flush) begin
      // Counters and the last issued instruction value survive a flush.
      r_state      <= ST_IDLE;
      r_prev_valid <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_EVAL;
        end

        ST_EVAL: begin
          if (w_hz_m[HZ_RAW] && (r_raw_cnt != {CNT_W{1'b1}})) r_raw_cnt <= r_raw_cnt + CNT_W'(1);
          if (w_hz_m[HZ_WAR] && (r_war_cnt != {CNT_W{1'b1}})) r_war_cnt <= r_war_cnt + CNT_W'(1);
          if (w_hz_m[HZ_WAW] && (r_waw_cnt != {CNT_W{1'b1}})) r_waw_cnt <= r_waw_cnt + CNT_W'(1);
          if (w_hz_m[HZ_RAW]) begin
            r_stall <= SW'(RAW_STALL - 1);
            r_state <= ST_STALL;
          end else if (w_hz_m[HZ_WAW]) begin
            r_stall <= SW'(WAW_STALL - 1);
            r_state <= ST_STALL;
          end else begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_head;
            r_state     <= ST_OFFER;
          end
        end

        ST_STALL: begin
          if (r_stall == '0) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_head;
            r_state     <= ST_OFFER;
          end else begin
            r_stall <= r_stall - 1'b1;
          end
        end

        ST_OFFER: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (!is_nop(r_out_instr)) begin
              r_prev       <= r_out_instr;
              r_prev_valid <= 1'b1;
            end
            r_state <= w_stay ? ST_EVAL : ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: timestamp-based reference model plus
// directed literal checks, followed by randomized traffic.
// Ports: none (top-level bench).
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int DEPTH     = 4;
  localparam int RAW_STALL = 2;
  localparam int WAW_STALL = 1;
  localparam int CNT_W     = 2;
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int NEVER     = 32'h7fffffff;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] raw_cnt;
  logic [CNT_W-1:0] war_cnt;
  logic [CNT_W-1:0] waw_cnt;

  issue_ctrl_if bus();

  issue_ctrl #(
    .DEPTH     (DEPTH),
    .RAW_STALL (RAW_STALL),
    .WAW_STALL (WAW_STALL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus),
    .raw_cnt (raw_cnt),
    .war_cnt (war_cnt),
    .waw_cnt (waw_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; each head gets an evaluation cycle
  // and an offer start cycle, and out_valid is simply "now has reached the offer cycle".
  logic [7:0] m_q[$];
  logic [7:0] m_prev   = 8'h00;
  bit         m_pv     = 1'b0;
  bit         m_sched  = 1'b0;
  bit         m_live   = 1'b0;
  int         m_now    = 0;
  int         m_eval_t = NEVER;
  int         m_offer_t = NEVER;
  int         m_raw = 0, m_war = 0, m_waw = 0;

  always @(posedge clk) begin : model_b
    bit         ov, pop, acc, was_ne;
    logic [2:0] h;
    int         st;
    logic [7:0] hd;
    if (!rst_n) begin
      m_q.delete();
      m_prev = 8'h00; m_pv = 1'b0; m_sched = 1'b0;
      m_raw = 0; m_war = 0; m_waw = 0;
      m_live = 1'b1;
    end else if (flush) begin
      m_q.delete();
      m_pv = 1'b0; m_sched = 1'b0;
    end else begin
      was_ne = m_q.size() > 0;
      ov     = m_sched && (m_now >= m_offer_t);
      pop    = ov && bus.out_ready;
      acc    = bus.in_valid && (m_q.size() < DEPTH);
      if (m_sched && m_now == m_eval_t) begin
        h  = (m_pv && m_q[0][7:6] != OP_NOP) ? bus.hz : 3'b000;
        st = h[HZ_RAW] ? RAW_STALL : (h[HZ_WAW] ? WAW_STALL : 0);
        m_offer_t = m_now + 1 + st;
        if (h[HZ_RAW] && m_raw < CMAX) m_raw++;
        if (h[HZ_WAR] && m_war < CMAX) m_war++;
        if (h[HZ_WAW] && m_waw < CMAX) m_waw++;
      end
      if (pop) begin
        hd = m_q.pop_front();
        if (hd[7:6] != OP_NOP) begin
          m_prev = hd;
          m_pv   = 1'b1;
        end
      end
      if (acc) m_q.push_back(bus.in_instr);
      if (pop) begin
        if (m_q.size() > 0) begin
          m_eval_t  = m_now + 1;
          m_offer_t = NEVER;
        end else begin
          m_sched = 1'b0;
        end
      end else if (!m_sched && was_ne) begin
        m_sched   = 1'b1;
        m_eval_t  = m_now + 1;
        m_offer_t = NEVER;
      end
    end
    m_now++;
  end

  always @(negedge clk) begin : cmp_b
    bit ev;
    if (m_live) begin
      ev = m_sched && (m_now >= m_offer_t);
      chk("in_ready", bus.in_ready, (m_q.size() < DEPTH) && !flush && rst_n);
      chk("out_valid", bus.out_valid, ev);
      if (ev) chk("out_instr", bus.out_instr, m_q[0]);
      chk("pair_x", bus.pair_x, m_prev);
      chk("pair_y", bus.pair_y, (m_q.size() > 0) ? m_q[0] : 8'h00);
      chk("raw_cnt", raw_cnt, m_raw);
      chk("war_cnt", war_cnt, m_war);
      chk("waw_cnt", waw_cnt, m_waw);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one instruction into an idle, empty block and measure the edge
  // (counted from the accepting edge) after which out_valid rises.
  task automatic issue_one(input logic [7:0] ins, input logic [2:0] h, output int lat);
    bus.in_instr  = ins;
    bus.in_valid  = 1'b1;
    bus.hz        = h;
    bus.out_ready = 1'b1;
    #1;
    chk("accept_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk("issue_timeout", lat, 1);
    tick();
  endtask

  initial begin : drive_b
    int         lat;
    int         idx;
    logic [7:0] vals [5];
    logic [7:0] got[$];

    bus.in_valid = 1'b0; bus.in_instr = 8'h00; bus.out_ready = 1'b0; bus.hz = 3'b000;
    rst_n = 1'b0; flush = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_pair_x", bus.pair_x, 8'h00);
    chk("rst_raw_cnt", raw_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    issue_one(8'h5D, 3'b000, lat);
    chk("lat_plain", lat, 2);
    chk("pair_x_5d", bus.pair_x, 8'h5D);
    chk("cnt_zero", {raw_cnt, war_cnt, waw_cnt}, 0);

    issue_one(8'h9B, 3'b100, lat);
    chk("lat_raw", lat, 4);
    chk("raw_cnt_1", raw_cnt, 1);

    issue_one(8'hD1, 3'b011, lat);
    chk("lat_waw", lat, 3);
    chk("war_cnt_1", war_cnt, 1);
    chk("waw_cnt_1", waw_cnt, 1);

    issue_one(8'h6A, 3'b010, lat);
    chk("lat_war_only", lat, 2);
    chk("war_cnt_2", war_cnt, 2);

    // Fill with the consumer blocked, then drain and check ordering.
    vals = '{8'h41, 8'h8A, 8'hC3, 8'h5C, 8'hE5};
    bus.hz = 3'b000;
    idx = 0;
    got.delete();
    for (int c = 0; c < 80 && got.size() < 5; c++) begin
      bus.in_valid  = (idx < 5);
      bus.in_instr  = vals[(idx < 5) ? idx : 0];
      bus.out_ready = (c >= 6);
      #1;
      if (c == 5) begin
        chk("full_in_ready", bus.in_ready, 0);
        chk("accepted_before_full", idx, 4);
      end
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_instr);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("drain_count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk("drain_order", got[i], vals[i]);
    end
    repeat (3) tick();

    // Flush in the middle of a RAW stall, with a competing write.
    bus.in_instr = 8'h9B; bus.in_valid = 1'b1; bus.hz = 3'b100; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("stall_no_offer", bus.out_valid, 0);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 8'h77;
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_fifo_empty", bus.pair_y, 8'h00);
    chk("raw_cnt_2", raw_cnt, 2);
    issue_one(8'h9B, 3'b111, lat);
    chk("lat_after_flush", lat, 2);
    chk("cnts_after_flush", {raw_cnt, war_cnt, waw_cnt}, {2'd2, 2'd2, 2'd1});

    // Saturation of the 2-bit RAW counter.
    for (int i = 0; i < 3; i++) begin
      issue_one(8'h9B, 3'b100, lat);
      chk("lat_raw_sat", lat, 4);
    end
    chk("raw_cnt_sat", raw_cnt, 3);

    // Randomized traffic; flush is kept off evaluation cycles.
    for (int c = 0; c < 4000; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      flush         = rst_n && ($urandom_range(0, 39) == 0) && !(m_sched && m_eval_t == m_now);
      bus.in_valid  = ($urandom_range(0, 9) < 6);
      bus.in_instr  = 8'($urandom);
      bus.hz        = 3'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
